// File: rtl/lsu_pkg.sv
// Shared types, exception causes and op-decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LD  = 4'd3,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_LWU = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10,
        OP_SD  = 4'd11
    } lsu_op_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsu_state_t;

    localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'd0;
    localparam logic [1:0] EXC_STORE_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_BUS_TIMEOUT    = 2'd2;
    localparam logic [1:0] EXC_RESERVED_OP    = 2'd3;

    // Codes 7 and 12..15 have no defined operation.
    function automatic logic op_is_reserved(input logic [3:0] op);
        return (op == 4'd7) || (op > 4'd11);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    // log2 of the access size in bytes: 0=byte, 1=half, 2=word, 3=double.
    function automatic logic [1:0] op_size_log2(input logic [3:0] op);
        logic [1:0] size;
        case (op)
            OP_LB, OP_LBU, OP_SB: size = 2'd0;
            OP_LH, OP_LHU, OP_SH: size = 2'd1;
            OP_LW, OP_LWU, OP_SW: size = 2'd2;
            default:              size = 2'd3;
        endcase
        return size;
    endfunction

    // Loads whose result is sign-extended; LD fills all 64 bits so it needs no extension.
    function automatic logic op_is_signed(input logic [3:0] op);
        return op inside {OP_LB, OP_LH, OP_LW};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask, store lane shift, misalign check on the
// incoming request, and extract/extend of the returned load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  req_op,
    input  logic [2:0]  req_lo,
    input  logic [63:0] req_wdata,
    output logic [7:0]  req_mask,
    output logic [63:0] req_lane_wdata,
    output logic        req_misaligned,
    input  logic [3:0]  ld_op,
    input  logic [2:0]  ld_lo,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_value
);

    logic [63:0] ld_shifted;
    logic        ld_signed;

    // Request side: byte enables, lane-shifted store data and alignment check.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        req_mask       = 8'h00;
        req_misaligned = 1'b0;
        req_lane_wdata = 64'd0;
        case (op_size_log2(req_op))
            2'd0: begin
                req_mask = 8'h01 << req_lo;
            end
            2'd1: begin
                req_mask       = 8'h03 << req_lo;
                req_misaligned = req_lo[0];
            end
            2'd2: begin
                req_mask       = 8'h0F << req_lo;
                req_misaligned = |req_lo[1:0];
            end
            default: begin
                req_mask       = 8'hFF;
                req_misaligned = |req_lo;
            end
        endcase
        if (op_is_store(req_op)) begin
            req_lane_wdata = req_wdata << {req_lo, 3'b000};
        end
    end

    // Load side: bring the addressed lane down to bit 0, then sign/zero extend.
    always_comb begin
        ld_shifted = ld_rdata >> {ld_lo, 3'b000};
        ld_signed  = op_is_signed(ld_op);
        ld_value   = ld_shifted;
        case (op_size_log2(ld_op))
            2'd0:    ld_value = {{56{ld_signed & ld_shifted[7]}},  ld_shifted[7:0]};
            2'd1:    ld_value = {{48{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            2'd2:    ld_value = {{32{ld_signed & ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_value = ld_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS64 memory stage: accepts one load/store per handshake, checks alignment,
// runs a single doubleword bus access and returns writeback or an exception.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ADDR_W         = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [7:0]        mem_mask,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [4:0]        wb_index,
    output logic [63:0]       wb_value,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_badvaddr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    // Counter value during the last ACCESS cycle that may still see an ack.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    lsu_state_t        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              mem_read_d, mem_write_d;
    logic [7:0]        mem_mask_d;
    logic [ADDR_W-1:0] mem_address_d;
    logic [63:0]       mem_wdata_d;
    logic              wb_valid_d;
    logic [4:0]        wb_index_d;
    logic [63:0]       wb_value_d;
    logic              exc_valid_d;
    logic [1:0]        exc_cause_d;
    logic [ADDR_W-1:0] exc_badvaddr_d;

    logic [7:0]        req_mask;
    logic [63:0]       req_lane_wdata;
    logic              req_misaligned;
    logic [63:0]       ld_value;
    logic              req_fire;
    logic              timeout_hit;

    lsu_align u_align (
        .req_op         (req_op),
        .req_lo         (req_addr[2:0]),
        .req_wdata      (req_wdata),
        .req_mask       (req_mask),
        .req_lane_wdata (req_lane_wdata),
        .req_misaligned (req_misaligned),
        .ld_op          (op_q),
        .ld_lo          (addr_q[2:0]),
        .ld_rdata       (mem_rdata),
        .ld_value       (ld_value)
    );

    assign req_ready   = (state_q == IDLE);
    assign req_fire    = req_valid && req_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == TIMEOUT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: only a legal, aligned request starts a bus access; ack or timeout ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (req_fire && !op_is_reserved(req_op) && !req_misaligned) state_d = ACCESS;
            ACCESS: if (mem_ack || timeout_hit) state_d = IDLE;
        endcase
    end

    // Output/datapath next values; bus outputs hold through ACCESS, pulses default low.
    always_comb begin
        op_d           = op_q;
        addr_d         = addr_q;
        rd_d           = rd_q;
        count_d        = count_q;
        mem_read_d     = mem_read;
        mem_write_d    = mem_write;
        mem_mask_d     = mem_mask;
        mem_address_d  = mem_address;
        mem_wdata_d    = mem_wdata;
        wb_valid_d     = 1'b0;
        wb_index_d     = wb_index;
        wb_value_d     = wb_value;
        exc_valid_d    = 1'b0;
        exc_cause_d    = exc_cause;
        exc_badvaddr_d = exc_badvaddr;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    if (op_is_reserved(req_op)) begin
                        exc_valid_d    = 1'b1;
                        exc_cause_d    = EXC_RESERVED_OP;
                        exc_badvaddr_d = req_addr;
                    end else if (req_misaligned) begin
                        exc_valid_d    = 1'b1;
                        exc_cause_d    = op_is_store(req_op) ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
                        exc_badvaddr_d = req_addr;
                    end else begin
                        op_d          = req_op;
                        addr_d        = req_addr;
                        rd_d          = req_rd;
                        count_d       = '0;
                        mem_read_d    = !op_is_store(req_op);
                        mem_write_d   = op_is_store(req_op);
                        mem_mask_d    = req_mask;
                        mem_address_d = {req_addr[ADDR_W-1:3], 3'b000};
                        mem_wdata_d   = req_lane_wdata;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack || timeout_hit) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_mask_d  = 8'h00;
                    mem_wdata_d = 64'd0;
                end
                if (mem_ack) begin
                    if (!op_is_store(op_q)) begin
                        wb_valid_d = (rd_q != 5'd0);
                        wb_index_d = rd_q;
                        wb_value_d = ld_value;
                    end
                end else if (timeout_hit) begin
                    exc_valid_d    = 1'b1;
                    exc_cause_d    = EXC_BUS_TIMEOUT;
                    exc_badvaddr_d = addr_q;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Registered bus, writeback and exception outputs plus latched request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= 4'd0;
            addr_q       <= '0;
            rd_q         <= 5'd0;
            count_q      <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_mask     <= 8'h00;
            mem_address  <= '0;
            mem_wdata    <= 64'd0;
            wb_valid     <= 1'b0;
            wb_index     <= 5'd0;
            wb_value     <= 64'd0;
            exc_valid    <= 1'b0;
            exc_cause    <= 2'd0;
            exc_badvaddr <= '0;
        end else begin
            op_q         <= op_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            mem_read     <= mem_read_d;
            mem_write    <= mem_write_d;
            mem_mask     <= mem_mask_d;
            mem_address  <= mem_address_d;
            mem_wdata    <= mem_wdata_d;
            wb_valid     <= wb_valid_d;
            wb_index     <= wb_index_d;
            wb_value     <= wb_value_d;
            exc_valid    <= exc_valid_d;
            exc_cause    <= exc_cause_d;
            exc_badvaddr <= exc_badvaddr_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, alignment, timeout,
// reserved op and reset during an access, against hand-computed values.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic [63:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_mask;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_index;
    logic [63:0] wb_value;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [63:0] exc_badvaddr;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(
        .TIMEOUT_CYCLES (4),
        .ADDR_W         (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_mask     (mem_mask),
        .mem_ack      (mem_ack),
        .wb_valid     (wb_valid),
        .wb_index     (wb_index),
        .wb_value     (wb_value),
        .exc_valid    (exc_valid),
        .exc_cause    (exc_cause),
        .exc_badvaddr (exc_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle.
    task automatic do_req(input logic [3:0] op, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        step();
        req_valid = 1'b0;
    endtask

    // Acknowledge the access in the current cycle.
    task automatic ack_now(input logic [63:0] rdata);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        req_rd    = 5'd0;
        mem_rdata = 64'd0;
        mem_ack   = 1'b0;

        // Reset state
        #3;
        check("rst mem_read", mem_read, 0);
        check("rst mem_write", mem_write, 0);
        check("rst mem_mask", mem_mask, 0);
        check("rst mem_address", mem_address, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst wb_valid", wb_valid, 0);
        check("rst exc_valid", exc_valid, 0);
        step();
        reset = 1'b0;
        step();
        check("rst req_ready", req_ready, 1);

        // LD 0x1000 rd 5, ack two cycles after the request
        do_req(4'd3, 64'h1000, 64'd0, 5'd5);
        check("ld mem_read", mem_read, 1);
        check("ld mem_write", mem_write, 0);
        check("ld mem_address", mem_address, 64'h1000);
        check("ld mem_mask", mem_mask, 8'hFF);
        check("ld mem_wdata", mem_wdata, 0);
        check("ld req_ready busy", req_ready, 0);
        step();
        check("ld hold mem_read", mem_read, 1);
        step();
        ack_now(64'h8877665544332211);
        check("ld wb_valid", wb_valid, 1);
        check("ld wb_index", wb_index, 5);
        check("ld wb_value", wb_value, 64'h8877665544332211);
        check("ld mem_read dropped", mem_read, 0);
        check("ld req_ready back", req_ready, 1);
        check("ld no exc", exc_valid, 0);
        step();
        check("ld wb pulse ends", wb_valid, 0);

        // LB then LBU at 0x2003; LBU issued in the cycle the LB writeback pulses
        do_req(4'd0, 64'h2003, 64'd0, 5'd7);
        check("lb mem_mask", mem_mask, 8'h08);
        check("lb mem_address", mem_address, 64'h2000);
        ack_now(64'h0000000080000000);
        check("lb wb_valid", wb_valid, 1);
        check("lb wb_value", wb_value, 64'hFFFFFFFFFFFFFF80);
        check("lb req_ready", req_ready, 1);
        do_req(4'd4, 64'h2003, 64'd0, 5'd8);
        check("lbu mem_mask", mem_mask, 8'h08);
        check("lbu mem_address", mem_address, 64'h2000);
        check("lbu mem_read", mem_read, 1);
        ack_now(64'h0000000080000000);
        check("lbu wb_valid", wb_valid, 1);
        check("lbu wb_index", wb_index, 8);
        check("lbu wb_value", wb_value, 64'h80);

        // SH 0x3006
        do_req(4'd9, 64'h3006, 64'hABCD, 5'd3);
        check("sh mem_write", mem_write, 1);
        check("sh mem_read", mem_read, 0);
        check("sh mem_mask", mem_mask, 8'hC0);
        check("sh mem_wdata", mem_wdata, 64'hABCD000000000000);
        check("sh mem_address", mem_address, 64'h3000);
        ack_now(64'hFFFFFFFFFFFFFFFF);
        check("sh no wb", wb_valid, 0);
        check("sh mem_write dropped", mem_write, 0);
        check("sh req_ready", req_ready, 1);

        // Misaligned LW and SD
        do_req(4'd2, 64'h4002, 64'd0, 5'd1);
        check("lw mis no read", mem_read, 0);
        check("lw mis exc_valid", exc_valid, 1);
        check("lw mis cause", exc_cause, 0);
        check("lw mis badvaddr", exc_badvaddr, 64'h4002);
        check("lw mis req_ready", req_ready, 1);
        check("lw mis no wb", wb_valid, 0);
        step();
        check("lw mis pulse ends", exc_valid, 0);
        do_req(4'd11, 64'h4004, 64'h1, 5'd0);
        check("sd mis no write", mem_write, 0);
        check("sd mis exc_valid", exc_valid, 1);
        check("sd mis cause", exc_cause, 1);
        check("sd mis badvaddr", exc_badvaddr, 64'h4004);
        step();

        // Timeout: LW 0x10 never acknowledged
        do_req(4'd2, 64'h10, 64'd0, 5'd4);
        for (int i = 0; i < 4; i++) begin
            check("to mem_read held", mem_read, 1);
            check("to no exc yet", exc_valid, 0);
            step();
        end
        check("to mem_read dropped", mem_read, 0);
        check("to exc_valid", exc_valid, 1);
        check("to cause", exc_cause, 2);
        check("to badvaddr", exc_badvaddr, 64'h10);
        check("to req_ready", req_ready, 1);
        ack_now(64'h1234);
        check("late ack no wb", wb_valid, 0);
        check("late ack no exc", exc_valid, 0);
        check("late ack no read", mem_read, 0);

        // Reserved op
        do_req(4'hF, 64'h5555, 64'd0, 5'd2);
        check("rsv exc_valid", exc_valid, 1);
        check("rsv cause", exc_cause, 3);
        check("rsv badvaddr", exc_badvaddr, 64'h5555);
        check("rsv no read", mem_read, 0);
        check("rsv no write", mem_write, 0);
        step();

        // Reset in the middle of an access
        do_req(4'd3, 64'h8000, 64'd0, 5'd9);
        check("mid mem_read", mem_read, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid rst mem_read", mem_read, 0);
        check("mid rst req_ready", req_ready, 1);
        step();
        reset = 1'b0;
        step();
        check("mid rst no wb", wb_valid, 0);
        check("mid rst no exc", exc_valid, 0);
        check("mid rst idle read", mem_read, 0);

        // Back-to-back: LW to r0 (no writeback), then SW right after the ack
        do_req(4'd2, 64'h20, 64'd0, 5'd0);
        check("b2b lw mem_read", mem_read, 1);
        ack_now(64'hDEADBEEFCAFEF00D);
        check("b2b lw rd0 no wb", wb_valid, 0);
        check("b2b ready after ack", req_ready, 1);
        do_req(4'd10, 64'h2C, 64'h12345678, 5'd6);
        check("b2b sw mem_write", mem_write, 1);
        check("b2b sw mem_mask", mem_mask, 8'hF0);
        check("b2b sw mem_wdata", mem_wdata, 64'h1234567800000000);
        check("b2b sw mem_address", mem_address, 64'h28);
        ack_now(64'd0);
        check("b2b sw no wb", wb_valid, 0);
        check("b2b sw write dropped", mem_write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
